opb_master_arbiter: RTL and testbench

Two-master OPB front end that shares the address decoder's DEC_RE/DEC_WE/DEC_ADDR bus between the host SPI bridge (M0) and the local status-scan sequencer (M1). It arbitrates round-robin and issues one single-beat read or write at a time. It waits the decoder's registered read-select latency, captures DEC_DO, and returns data plus a one-cycle ACK to the owning master.

---
 rtl/opb_arb_pkg.sv | 25 ++
 rtl/opb_master_arbiter_if.sv | 50 +++++
 rtl/rr_arb2.sv | 26 ++
 rtl/opb_master_arbiter.sv | 155 +++++++++++++++
 tb/tb_opb_master_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/opb_arb_pkg.sv
// Shared types and constants for the two-master OPB arbiter.
package opb_arb_pkg;

  // Transfer sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // Master identifiers as carried on GNT_ID.
  localparam logic M0_ID = 1'b0;
  localparam logic M1_ID = 1'b1;

  // Default decoder read latency and latency counter width.
  localparam int RD_LATENCY_DEF = 1;
  localparam int CNT_W          = 4;

  // The master that gets priority after the given owner has been served.
  function automatic logic other_id(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/opb_master_arbiter_if.sv
// Bundle of master request/response signals and decoder bus signals.
interface opb_master_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;

  logic              dec_re;
  logic              dec_we;
  logic [ADDR_W-1:0] dec_addr;
  logic [DATA_W-1:0] dec_di;
  logic [DATA_W-1:0] dec_do;

  logic              busy;
  logic              gnt_id;

  // Arbiter side: takes requests and decoder read data, drives everything else.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  dec_do,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output dec_re, dec_we, dec_addr, dec_di,
    output busy, gnt_id
  );

  // Environment side: masters plus decoder.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output dec_do,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  dec_re, dec_we, dec_addr, dec_di,
    input  busy, gnt_id
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-request round-robin pick. The pointer names the master that wins a tie;
// the pointer register itself is owned by the parent.
module rr_arb2
  import opb_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic ptr_i,
  output logic gnt_o,
  output logic id_o
);

  // Grant whenever anyone asks; tie goes to the pointer's master.
  always_comb begin
    gnt_o = req0_i | req1_i;
    id_o  = M0_ID;
    if (req0_i && req1_i) begin
      id_o = ptr_i;
    end else if (req1_i) begin
      id_o = M1_ID;
    end else begin
      id_o = M0_ID;
    end
  end

endmodule

// File: rtl/opb_master_arbiter.sv
// Two-master OPB front end: round-robin selects M0 or M1, issues one
// single-beat access to the address decoder, waits the read latency,
// captures DEC_DO and returns it with a one-cycle ACK.
module opb_master_arbiter
  import opb_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = RD_LATENCY_DEF
) (
  input  logic                 OPB_CLK,
  input  logic                 OPB_RST,
  opb_master_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_e        state_q;
  logic              ptr_q;
  logic              gnt_id_q;
  logic              we_q;
  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              dec_re_q;
  logic              dec_we_q;
  logic [ADDR_W-1:0] dec_addr_q;
  logic [DATA_W-1:0] dec_di_q;
  logic              m0_ack_q;
  logic              m1_ack_q;
  logic [DATA_W-1:0] m0_rdata_q;
  logic [DATA_W-1:0] m1_rdata_q;

  logic              arb_gnt_s;
  logic              arb_id_s;
  logic              win_we_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_wdata_s;

  rr_arb2 u_rr_arb2 (
    .req0_i (bus.m0_req),
    .req1_i (bus.m1_req),
    .ptr_i  (ptr_q),
    .gnt_o  (arb_gnt_s),
    .id_o   (arb_id_s)
  );

  // Route the winning master's command fields toward the latch.
  always_comb begin
    win_we_s    = bus.m0_we;
    win_addr_s  = bus.m0_addr;
    win_wdata_s = bus.m0_wdata;
    if (arb_id_s == M1_ID) begin
      win_we_s    = bus.m1_we;
      win_addr_s  = bus.m1_addr;
      win_wdata_s = bus.m1_wdata;
    end else begin
      win_we_s    = bus.m0_we;
      win_addr_s  = bus.m0_addr;
      win_wdata_s = bus.m0_wdata;
    end
  end

  // Transfer sequencer; all bus-visible outputs are registered here so the
  // strobe and ACK land exactly in the ISSUE and DONE cycles.
  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      state_q    <= ST_IDLE;
      ptr_q      <= M0_ID;
      gnt_id_q   <= M0_ID;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      dec_re_q   <= 1'b0;
      dec_we_q   <= 1'b0;
      dec_addr_q <= '0;
      dec_di_q   <= '0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      // Strobes and ACKs are single-cycle pulses.
      dec_re_q <= 1'b0;
      dec_we_q <= 1'b0;
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_gnt_s) begin
            gnt_id_q   <= arb_id_s;
            we_q       <= win_we_s;
            dec_addr_q <= win_addr_s;
            dec_di_q   <= win_wdata_s;
            dec_re_q   <= ~win_we_s;
            dec_we_q   <= win_we_s;
            busy_q     <= 1'b1;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (we_q) begin
            // Writes complete without waiting on the decoder.
            dec_addr_q <= '0;
            dec_di_q   <= '0;
            m0_ack_q   <= (gnt_id_q == M0_ID);
            m1_ack_q   <= (gnt_id_q == M1_ID);
            state_q    <= ST_DONE;
          end else begin
            cnt_q   <= LAT_LOAD;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CNT_ONE;
          // Counter at one marks the cycle DEC_DO is valid; <= also
          // guards against an out-of-range zero latency hanging here.
          if (cnt_q <= CNT_ONE) begin
            if (gnt_id_q == M1_ID) begin
              m1_rdata_q <= bus.dec_do;
            end else begin
              m0_rdata_q <= bus.dec_do;
            end
            dec_addr_q <= '0;
            dec_di_q   <= '0;
            m0_ack_q   <= (gnt_id_q == M0_ID);
            m1_ack_q   <= (gnt_id_q == M1_ID);
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          ptr_q   <= other_id(gnt_id_q);
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.dec_re   = dec_re_q;
  assign bus.dec_we   = dec_we_q;
  assign bus.dec_addr = dec_addr_q;
  assign bus.dec_di   = dec_di_q;
  assign bus.m0_ack   = m0_ack_q;
  assign bus.m1_ack   = m1_ack_q;
  assign bus.m0_rdata = m0_rdata_q;
  assign bus.m1_rdata = m1_rdata_q;
  assign bus.busy     = busy_q;
  assign bus.gnt_id   = gnt_id_q;

endmodule

// File: tb/tb_opb_master_arbiter.sv
// Self-checking bench: directed scenarios on two arbiter instances
// (read latency 1 and 3) plus randomized traffic against a schedule model.
module tb_opb_master_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  opb_master_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  opb_master_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

  opb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(LAT_A)) dut_a (
    .OPB_CLK (clk),
    .OPB_RST (rst),
    .bus     (bus_a)
  );

  opb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(LAT_B)) dut_b (
    .OPB_CLK (clk),
    .OPB_RST (rst),
    .bus     (bus_b)
  );

  function automatic logic [133:0] outs_a();
    return {bus_a.m0_ack, bus_a.m1_ack, bus_a.m0_rdata, bus_a.m1_rdata, bus_a.dec_re,
            bus_a.dec_we, bus_a.dec_addr, bus_a.dec_di, bus_a.busy, bus_a.gnt_id};
  endfunction

  function automatic logic [133:0] outs_b();
    return {bus_b.m0_ack, bus_b.m1_ack, bus_b.m0_rdata, bus_b.m1_rdata, bus_b.dec_re,
            bus_b.dec_we, bus_b.dec_addr, bus_b.dec_di, bus_b.busy, bus_b.gnt_id};
  endfunction

  task automatic idle_all();
    bus_a.m0_req = 1'b0; bus_a.m0_we = 1'b0; bus_a.m0_addr = 32'h0; bus_a.m0_wdata = 32'h0;
    bus_a.m1_req = 1'b0; bus_a.m1_we = 1'b0; bus_a.m1_addr = 32'h0; bus_a.m1_wdata = 32'h0;
    bus_a.dec_do = 32'h0;
    bus_b.m0_req = 1'b0; bus_b.m0_we = 1'b0; bus_b.m0_addr = 32'h0; bus_b.m0_wdata = 32'h0;
    bus_b.m1_req = 1'b0; bus_b.m1_we = 1'b0; bus_b.m1_addr = 32'h0; bus_b.m1_wdata = 32'h0;
    bus_b.dec_do = 32'h0;
  endtask

  task automatic drain_a();
    for (int i = 0; i < 20 && bus_a.busy; i++) @(negedge clk);
    n_checks++;
    if (bus_a.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL drain_a: busy got %b expected 0 within 20 cycles", bus_a.busy);
    end
  endtask

  task automatic test_reset();
    logic [133:0] v;
    rst = 1'b1;
    bus_a.m0_req = 1'b1;
    bus_b.m1_req = 1'b1;
    repeat (2) @(negedge clk);
    v = outs_a();
    n_checks++;
    if (v !== 134'd0) begin
      n_errors++;
      $display("FAIL reset_a: outputs got %h expected 0", v);
    end
    v = outs_b();
    n_checks++;
    if (v !== 134'd0) begin
      n_errors++;
      $display("FAIL reset_b: outputs got %h expected 0", v);
    end
    idle_all();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    v = outs_a();
    n_checks++;
    if (v !== 134'd0) begin
      n_errors++;
      $display("FAIL post_reset_idle: outputs got %h expected 0", v);
    end
  endtask

  task automatic test_read_m0();
    logic [5:0]  re_m, ack0_m, ack1_m, busy_m;
    logic [31:0] rd, addr_s;
    re_m = '0; ack0_m = '0; ack1_m = '0; busy_m = '0; rd = 32'h0; addr_s = 32'h0;
    bus_a.m0_we = 1'b0; bus_a.m0_addr = 32'h0000_0100; bus_a.m0_wdata = 32'h0; bus_a.m0_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      re_m[k] = bus_a.dec_re; ack0_m[k] = bus_a.m0_ack; ack1_m[k] = bus_a.m1_ack; busy_m[k] = bus_a.busy;
      if (bus_a.dec_re) addr_s = bus_a.dec_addr;
      if (bus_a.m0_ack) begin rd = bus_a.m0_rdata; bus_a.m0_req = 1'b0; end
      bus_a.dec_do = (k == 2) ? 32'hCAFE_0001 : $urandom();
      @(negedge clk);
    end
    n_checks++;
    if (re_m !== 6'b000010) begin n_errors++; $display("FAIL rd_m0 dec_re: got %b expected 000010", re_m); end
    n_checks++;
    if (ack0_m !== 6'b001000) begin n_errors++; $display("FAIL rd_m0 m0_ack: got %b expected 001000", ack0_m); end
    n_checks++;
    if (ack1_m !== 6'b000000) begin n_errors++; $display("FAIL rd_m0 m1_ack: got %b expected 000000", ack1_m); end
    n_checks++;
    if (busy_m !== 6'b001110) begin n_errors++; $display("FAIL rd_m0 busy: got %b expected 001110", busy_m); end
    n_checks++;
    if (rd !== 32'hCAFE_0001) begin n_errors++; $display("FAIL rd_m0 rdata: got %h expected cafe0001", rd); end
    n_checks++;
    if (addr_s !== 32'h0000_0100) begin n_errors++; $display("FAIL rd_m0 dec_addr: got %h expected 00000100", addr_s); end
    n_checks++;
    if (bus_a.gnt_id !== 1'b0) begin n_errors++; $display("FAIL rd_m0 gnt_id: got %b expected 0", bus_a.gnt_id); end
  endtask

  task automatic test_write_m1();
    logic [5:0]  re_m, we_m, ack0_m, ack1_m;
    logic [31:0] addr_s, di_s;
    logic        gid_s;
    re_m = '0; we_m = '0; ack0_m = '0; ack1_m = '0; addr_s = 32'h0; di_s = 32'h0; gid_s = 1'b0;
    bus_a.m1_we = 1'b1; bus_a.m1_addr = 32'h0000_0200; bus_a.m1_wdata = 32'h0000_00A5; bus_a.m1_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      re_m[k] = bus_a.dec_re; we_m[k] = bus_a.dec_we; ack0_m[k] = bus_a.m0_ack; ack1_m[k] = bus_a.m1_ack;
      if (bus_a.dec_we) begin addr_s = bus_a.dec_addr; di_s = bus_a.dec_di; gid_s = bus_a.gnt_id; end
      if (bus_a.m1_ack) bus_a.m1_req = 1'b0;
      bus_a.dec_do = $urandom();
      @(negedge clk);
    end
    n_checks++;
    if (we_m !== 6'b000010) begin n_errors++; $display("FAIL wr_m1 dec_we: got %b expected 000010", we_m); end
    n_checks++;
    if (re_m !== 6'b000000) begin n_errors++; $display("FAIL wr_m1 dec_re: got %b expected 000000", re_m); end
    n_checks++;
    if (ack1_m !== 6'b000100) begin n_errors++; $display("FAIL wr_m1 m1_ack: got %b expected 000100", ack1_m); end
    n_checks++;
    if (ack0_m !== 6'b000000) begin n_errors++; $display("FAIL wr_m1 m0_ack: got %b expected 000000", ack0_m); end
    n_checks++;
    if (addr_s !== 32'h0000_0200 || di_s !== 32'h0000_00A5) begin
      n_errors++; $display("FAIL wr_m1 addr/di: got %h/%h expected 00000200/000000a5", addr_s, di_s);
    end
    n_checks++;
    if (gid_s !== 1'b1) begin n_errors++; $display("FAIL wr_m1 gnt_id: got %b expected 1", gid_s); end
    n_checks++;
    if (bus_a.m0_rdata !== 32'hCAFE_0001) begin
      n_errors++; $display("FAIL wr_m1 m0_rdata_kept: got %h expected cafe0001", bus_a.m0_rdata);
    end
  endtask

  task automatic test_fairness();
    int   ns, ack0n, ack1n;
    int   sc[4];
    logic own[4];
    logic gid[4];
    ns = 0; ack0n = 0; ack1n = 0;
    for (int i = 0; i < 4; i++) begin sc[i] = 0; own[i] = 1'b0; gid[i] = 1'b0; end
    bus_a.m0_we = 1'b1; bus_a.m0_addr = 32'h10; bus_a.m0_wdata = 32'h111; bus_a.m0_req = 1'b1;
    bus_a.m1_we = 1'b1; bus_a.m1_addr = 32'h20; bus_a.m1_wdata = 32'h222; bus_a.m1_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (bus_a.dec_we || bus_a.dec_re) begin
        if (ns < 4) begin sc[ns] = k; own[ns] = (bus_a.dec_addr == 32'h20); gid[ns] = bus_a.gnt_id; end
        ns++;
      end
      if (bus_a.m0_ack) ack0n++;
      if (bus_a.m1_ack) ack1n++;
      @(negedge clk);
    end
    bus_a.m0_req = 1'b0;
    bus_a.m1_req = 1'b0;
    n_checks++;
    if (ns !== 4) begin n_errors++; $display("FAIL fair strobe_count: got %0d expected 4", ns); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (own[i] !== ((i % 2) == 1) || gid[i] !== ((i % 2) == 1) || sc[i] !== 1 + 3 * i) begin
        n_errors++;
        $display("FAIL fair xfer%0d: got owner %b gnt %b cycle %0d expected owner %0d cycle %0d",
                 i, own[i], gid[i], sc[i], i % 2, 1 + 3 * i);
      end
    end
    n_checks++;
    if (ack0n !== 2 || ack1n !== 2) begin
      n_errors++; $display("FAIL fair ack_counts: got %0d/%0d expected 2/2", ack0n, ack1n);
    end
    drain_a();
  endtask

  task automatic test_latency3();
    logic [7:0]  re_m, ack0_m, ack1_m, busy_m;
    logic [31:0] rd;
    re_m = '0; ack0_m = '0; ack1_m = '0; busy_m = '0; rd = 32'h0;
    bus_b.m1_we = 1'b0; bus_b.m1_addr = 32'h0000_0300; bus_b.m1_wdata = 32'h0; bus_b.m1_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      re_m[k] = bus_b.dec_re; ack0_m[k] = bus_b.m0_ack; ack1_m[k] = bus_b.m1_ack; busy_m[k] = bus_b.busy;
      if (bus_b.m1_ack) begin rd = bus_b.m1_rdata; bus_b.m1_req = 1'b0; end
      if (k == 2 || k == 3) bus_b.dec_do = 32'h1111_1111;
      else if (k == 4) bus_b.dec_do = 32'h2222_2222;
      else if (k > 4) bus_b.dec_do = 32'h3333_3333;
      else bus_b.dec_do = $urandom();
      @(negedge clk);
    end
    n_checks++;
    if (re_m !== 8'b00000010) begin n_errors++; $display("FAIL lat3 dec_re: got %b expected 00000010", re_m); end
    n_checks++;
    if (ack1_m !== 8'b00100000) begin n_errors++; $display("FAIL lat3 m1_ack: got %b expected 00100000", ack1_m); end
    n_checks++;
    if (ack0_m !== 8'b00000000) begin n_errors++; $display("FAIL lat3 m0_ack: got %b expected 00000000", ack0_m); end
    n_checks++;
    if (busy_m !== 8'b00111110) begin n_errors++; $display("FAIL lat3 busy: got %b expected 00111110", busy_m); end
    n_checks++;
    if (rd !== 32'h2222_2222) begin n_errors++; $display("FAIL lat3 rdata: got %h expected 22222222", rd); end
  endtask

  task automatic test_reset_mid();
    logic [7:0]   re_m, ack0_m;
    logic [4:0]   we_m, ack1_m;
    logic [133:0] v;
    re_m = '0; ack0_m = '0; we_m = '0; ack1_m = '0; v = '1;
    bus_b.m0_we = 1'b0; bus_b.m0_addr = 32'h0000_0400; bus_b.m0_wdata = 32'h0; bus_b.m0_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      re_m[k] = bus_b.dec_re; ack0_m[k] = bus_b.m0_ack;
      if (k == 2) rst = 1'b1;
      if (k == 3) begin v = outs_b(); rst = 1'b0; bus_b.m0_req = 1'b0; end
      bus_b.dec_do = $urandom();
      @(negedge clk);
    end
    n_checks++;
    if (v !== 134'd0) begin n_errors++; $display("FAIL rst_mid outputs: got %h expected 0", v); end
    n_checks++;
    if (ack0_m !== 8'b00000000) begin n_errors++; $display("FAIL rst_mid m0_ack: got %b expected 00000000", ack0_m); end
    n_checks++;
    if (re_m !== 8'b00000010) begin n_errors++; $display("FAIL rst_mid dec_re: got %b expected 00000010", re_m); end
    bus_b.m1_we = 1'b1; bus_b.m1_addr = 32'h0000_0500; bus_b.m1_wdata = 32'h0000_005A; bus_b.m1_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      we_m[k] = bus_b.dec_we; ack1_m[k] = bus_b.m1_ack;
      if (bus_b.m1_ack) bus_b.m1_req = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (we_m !== 5'b00010 || ack1_m !== 5'b00100) begin
      n_errors++; $display("FAIL rst_mid m1_write: got we %b ack %b expected 00010/00100", we_m, ack1_m);
    end
    n_checks++;
    if (bus_b.m1_rdata !== 32'h0 || bus_b.gnt_id !== 1'b1) begin
      n_errors++; $display("FAIL rst_mid m1_after: got rdata %h gnt %b expected 0/1", bus_b.m1_rdata, bus_b.gnt_id);
    end
  endtask

  task automatic test_req_drop();
    logic [7:0] re_m, ack0_m;
    re_m = '0; ack0_m = '0;
    bus_a.m0_we = 1'b0; bus_a.m0_addr = 32'h0000_0180; bus_a.m0_wdata = 32'h0; bus_a.m0_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      re_m[k] = bus_a.dec_re; ack0_m[k] = bus_a.m0_ack;
      if (k == 2) bus_a.m0_req = 1'b0;
      bus_a.dec_do = (k == 2) ? 32'hBEEF_0002 : $urandom();
      @(negedge clk);
    end
    n_checks++;
    if (re_m !== 8'b00000010) begin n_errors++; $display("FAIL req_drop dec_re: got %b expected 00000010", re_m); end
    n_checks++;
    if (ack0_m !== 8'b00001000) begin n_errors++; $display("FAIL req_drop m0_ack: got %b expected 00001000", ack0_m); end
    n_checks++;
    if (bus_a.m0_rdata !== 32'hBEEF_0002) begin
      n_errors++; $display("FAIL req_drop rdata: got %h expected beef0002", bus_a.m0_rdata);
    end
  endtask

  // Random traffic on the latency-1 instance. The model works at the level of
  // whole transfers: when the arbiter is free and someone asks, it fixes the
  // winner and the cycle numbers of strobe, data sample and ACK.
  task automatic test_random();
    logic        act[2];
    logic        mwe[2];
    logic [31:0] maddr[2];
    logic [31:0] mwd[2];
    logic [31:0] rd_m[2];
    int          free_c, s_strobe, s_samp, s_ack;
    logic        last_own, gnt_m, s_v, s_own, s_we, w;
    logic [31:0] s_addr, s_di, s_cap, dd, e_addr, e_di;
    logic        e_re, e_we, e_busy, e_ack0, e_ack1;
    logic [5:0]  e_ctl, g_ctl;
    for (int m = 0; m < 2; m++) begin act[m] = 1'b0; mwe[m] = 1'b0; maddr[m] = 32'h0; mwd[m] = 32'h0; rd_m[m] = 32'h0; end
    free_c = 0; s_strobe = -10; s_samp = -10; s_ack = -10;
    last_own = 1'b1; gnt_m = 1'b0; s_v = 1'b0; s_own = 1'b0; s_we = 1'b0; w = 1'b0;
    s_addr = 32'h0; s_di = 32'h0; s_cap = 32'h0;
    idle_all();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 800; c++) begin
      e_re   = s_v && (c == s_strobe) && !s_we;
      e_we   = s_v && (c == s_strobe) && s_we;
      e_busy = s_v && (c >= s_strobe) && (c <= s_ack);
      e_addr = (s_v && c >= s_strobe && c < s_ack) ? s_addr : 32'h0;
      e_di   = (s_v && c >= s_strobe && c < s_ack) ? s_di : 32'h0;
      if (s_v && c == s_strobe) gnt_m = s_own;
      e_ack0 = s_v && (c == s_ack) && (s_own == 1'b0);
      e_ack1 = s_v && (c == s_ack) && (s_own == 1'b1);
      if (s_v && c == s_ack && !s_we) rd_m[s_own] = s_cap;
      e_ctl = {e_re, e_we, e_busy, gnt_m, e_ack0, e_ack1};
      g_ctl = {bus_a.dec_re, bus_a.dec_we, bus_a.busy, bus_a.gnt_id, bus_a.m0_ack, bus_a.m1_ack};
      n_checks++;
      if (g_ctl !== e_ctl) begin
        n_errors++; $display("FAIL rand ctl c=%0d: got re,we,busy,gnt,ack0,ack1=%b expected %b", c, g_ctl, e_ctl);
      end
      n_checks++;
      if (bus_a.dec_addr !== e_addr || bus_a.dec_di !== e_di) begin
        n_errors++; $display("FAIL rand bus c=%0d: got %h/%h expected %h/%h", c, bus_a.dec_addr, bus_a.dec_di, e_addr, e_di);
      end
      n_checks++;
      if (bus_a.m0_rdata !== rd_m[0] || bus_a.m1_rdata !== rd_m[1]) begin
        n_errors++; $display("FAIL rand rdata c=%0d: got %h/%h expected %h/%h", c, bus_a.m0_rdata, bus_a.m1_rdata, rd_m[0], rd_m[1]);
      end
      for (int m = 0; m < 2; m++) begin
        if (act[m] && s_v && c == s_ack && s_own == (m == 1)) begin
          act[m] = 1'b0;
        end else if (!act[m] && $urandom_range(0, 2) == 0) begin
          act[m] = 1'b1; mwe[m] = ($urandom_range(0, 1) == 1); maddr[m] = $urandom(); mwd[m] = $urandom();
        end
      end
      bus_a.m0_req = act[0]; bus_a.m0_we = mwe[0]; bus_a.m0_addr = maddr[0]; bus_a.m0_wdata = mwd[0];
      bus_a.m1_req = act[1]; bus_a.m1_we = mwe[1]; bus_a.m1_addr = maddr[1]; bus_a.m1_wdata = mwd[1];
      dd = $urandom();
      bus_a.dec_do = dd;
      if (s_v && c == s_samp && !s_we) s_cap = dd;
      if (c >= free_c && (act[0] || act[1])) begin
        if (act[0] && act[1]) w = ~last_own;
        else w = act[1];
        s_v = 1'b1; s_own = w; s_we = mwe[w]; s_addr = maddr[w]; s_di = mwd[w];
        s_strobe = c + 1;
        s_samp   = c + 1 + LAT_A;
        s_ack    = s_we ? c + 2 : c + 2 + LAT_A;
        free_c   = s_ack + 1;
        last_own = w;
      end
      @(negedge clk);
    end
    idle_all();
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    @(negedge clk);
    test_reset();
    test_read_m0();
    test_write_m1();
    test_fairness();
    test_latency3();
    test_reset_mid();
    test_req_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
